// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_seq_pkg
// Brief   : Shared constants for the ALU control-step sequencer: opcode
//           values, ALU function count, bus-source offsets above the register
//           file, and the sequencer state encoding.
//           Optional feature macro: ALU_SEQ_MULDIV_EN (see alu_step_sequencer).
// Revision: 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

  // Opcodes, held 32 bits wide so they compare cleanly against any OP_W.
  localparam logic [31:0] OP_ADD = 32'd0;
  localparam logic [31:0] OP_SUB = 32'd1;
  localparam logic [31:0] OP_AND = 32'd2;
  localparam logic [31:0] OP_OR  = 32'd3;
  localparam logic [31:0] OP_NOT = 32'd4;
  localparam logic [31:0] OP_NEG = 32'd5;
  localparam logic [31:0] OP_SHL = 32'd6;
  localparam logic [31:0] OP_SHR = 32'd7;
  localparam logic [31:0] OP_MUL = 32'd8;
  localparam logic [31:0] OP_DIV = 32'd9;

  // Number of one-hot ALU function lines.
  localparam int ALU_OPS_CNT = 10;

  // Bus-source indices above the general registers (add NUM_REGS).
  localparam int SRC_HI     = 0;
  localparam int SRC_LO     = 1;
  localparam int SRC_ZHI    = 2;
  localparam int SRC_ZLO    = 3;
  localparam int SRC_PC     = 4;
  localparam int SRC_MDR    = 5;
  localparam int SRC_INPORT = 6;
  localparam int SRC_CSIGN  = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_Y   = 3'd1,
    S_ALU = 3'd2,
    S_WLO = 3'd3,
    S_WHI = 3'd4,
    S_ERR = 3'd5
  } state_t;

  // Single-operand functions skip the Y load.
  function automatic logic op_is_unary(input logic [31:0] o);
    return (o == OP_NOT) || (o == OP_NEG);
  endfunction

  // Functions producing a 64-bit result written to HI/LO.
  function automatic logic op_is_muldiv(input logic [31:0] o);
    return (o == OP_MUL) || (o == OP_DIV);
  endfunction

  // Functions that are always available (ADD..SHR).
  function automatic logic op_is_base(input logic [31:0] o);
    return o <= OP_SHR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_step_sequencer_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module  : onehot_dec
// Brief   : Binary index to one-hot decoder with enable. Output is all-zero
//           when disabled or when the index lies outside OUT_W.
// Ports   : idx    in  IN_W   binary index
//           en     in  1      decode enable
//           onehot out OUT_W  one-hot result
// Revision: 1.0 - initial release
// ============================================================================
module onehot_dec #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  idx,
  input  logic             en,
  output logic [OUT_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < OUT_W; i++) begin
      onehot[i] = en && (32'(idx) == 32'(i));
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_step_sequencer
// Brief   : Control-step sequencer for the bus-based datapath. Accepts one
//           register-to-register ALU instruction (ra <= rb OP rc/MDR) and
//           steps through Y load, ALU/Z load and result write-back, one step
//           per cycle. All outputs are Moore, decoded from the registered
//           state and the fields latched on acceptance.
// Config  : `define ALU_SEQ_MULDIV_EN enables MUL/DIV with the LO then HI
//           write-back; without it opcodes 8/9 are rejected and hi_in/lo_in
//           are constant 0.
// Ports   : Clock    in   1          rising-edge clock
//           Clear    in   1          synchronous active-high reset
//           start    in   1          request, sampled only in IDLE
//           op       in   OP_W       opcode
//           ra/rb/rc in   REG_IDX_W  destination / operand A / operand B
//           b_is_mdr in   1          operand B from MDR instead of rc
//           busy     out  1          high in every non-IDLE state
//           done     out  1          pulse in the final write step
//           err      out  1          pulse for a rejected opcode
//           bus_sel  out  NUM_SRC    one-hot bus source
//           reg_in   out  NUM_REGS   one-hot register load enable
//           y_in, z_in, hi_in, lo_in out 1  Y / Z / HI / LO load enables
//           alu_ctl  out  ALU_OPS    one-hot ALU function
// Revision: 1.0 - initial release
// ============================================================================
module alu_step_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int OP_W      = 4,
  parameter int ALU_OPS   = ALU_OPS_CNT,
  parameter int NUM_SRC   = NUM_REGS + 8
) (
  input  logic                 Clock,
  input  logic                 Clear,
  input  logic                 start,
  input  logic [OP_W-1:0]      op,
  input  logic [REG_IDX_W-1:0] ra,
  input  logic [REG_IDX_W-1:0] rb,
  input  logic [REG_IDX_W-1:0] rc,
  input  logic                 b_is_mdr,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [NUM_SRC-1:0]   bus_sel,
  output logic [NUM_REGS-1:0]  reg_in,
  output logic                 y_in,
  output logic                 z_in,
  output logic                 hi_in,
  output logic                 lo_in,
  output logic [ALU_OPS-1:0]   alu_ctl
);

  localparam int SRC_IDX_W = $clog2(NUM_SRC);

  state_t               r_state;
  state_t               w_next;
  logic [OP_W-1:0]      r_op;
  logic [REG_IDX_W-1:0] r_ra;
  logic [REG_IDX_W-1:0] r_rb;
  logic [REG_IDX_W-1:0] r_rc;
  logic                 r_b_is_mdr;

  logic                 w_in_legal;
  logic                 w_in_unary;
  logic                 w_cur_unary;
  logic                 w_src_en;
  logic [SRC_IDX_W-1:0] w_src_idx;
  logic                 w_reg_en;
  logic                 w_alu_en;
  logic                 w_y;
  logic                 w_z;
  logic                 w_done;
  logic                 w_err;

  // Legality and class are judged on the incoming opcode so the IDLE step
  // can branch in the same cycle the fields are latched.
`ifdef ALU_SEQ_MULDIV_EN
  logic w_cur_muldiv;
  logic w_hi;
  logic w_lo;
  assign w_in_legal   = op_is_base(32'(op)) || op_is_muldiv(32'(op));
  assign w_cur_muldiv = op_is_muldiv(32'(r_op));
`else
  assign w_in_legal   = op_is_base(32'(op));
`endif
  assign w_in_unary  = op_is_unary(32'(op));
  assign w_cur_unary = op_is_unary(32'(r_op));

  always_ff @(posedge Clock) begin
    if (Clear) begin
      r_state    <= IDLE;
      r_op       <= '0;
      r_ra       <= '0;
      r_rb       <= '0;
      r_rc       <= '0;
      r_b_is_mdr <= 1'b0;
    end else begin
      r_state <= w_next;
      // Fields are captured only on acceptance; requests while busy are
      // ignored and leave the in-flight instruction untouched.
      if (r_state == IDLE && start) begin
        r_op       <= op;
        r_ra       <= ra;
        r_rb       <= rb;
        r_rc       <= rc;
        r_b_is_mdr <= b_is_mdr;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_src_en  = 1'b0;
    w_src_idx = '0;
    w_reg_en  = 1'b0;
    w_alu_en  = 1'b0;
    w_y       = 1'b0;
    w_z       = 1'b0;
    w_done    = 1'b0;
    w_err     = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
    w_hi      = 1'b0;
    w_lo      = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          if (!w_in_legal)     w_next = S_ERR;
          else if (w_in_unary) w_next = S_ALU;
          else                 w_next = S_Y;
        end
      end
      S_Y: begin
        w_src_en  = 1'b1;
        w_src_idx = SRC_IDX_W'(r_rb);
        w_y       = 1'b1;
        w_next    = S_ALU;
      end
      S_ALU: begin
        // Unary ops read their only operand straight from rb here.
        w_src_en = 1'b1;
        if (w_cur_unary)     w_src_idx = SRC_IDX_W'(r_rb);
        else if (r_b_is_mdr) w_src_idx = SRC_IDX_W'(NUM_REGS + SRC_MDR);
        else                 w_src_idx = SRC_IDX_W'(r_rc);
        w_alu_en = 1'b1;
        w_z      = 1'b1;
        w_next   = S_WLO;
      end
      S_WLO: begin
        w_src_en  = 1'b1;
        w_src_idx = SRC_IDX_W'(NUM_REGS + SRC_ZLO);
`ifdef ALU_SEQ_MULDIV_EN
        if (w_cur_muldiv) begin
          w_lo   = 1'b1;
          w_next = S_WHI;
        end else begin
          w_reg_en = 1'b1;
          w_done   = 1'b1;
          w_next   = IDLE;
        end
`else
        w_reg_en = 1'b1;
        w_done   = 1'b1;
        w_next   = IDLE;
`endif
      end
`ifdef ALU_SEQ_MULDIV_EN
      S_WHI: begin
        w_src_en  = 1'b1;
        w_src_idx = SRC_IDX_W'(NUM_REGS + SRC_ZHI);
        w_hi      = 1'b1;
        w_done    = 1'b1;
        w_next    = IDLE;
      end
`endif
      S_ERR: begin
        w_err  = 1'b1;
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  onehot_dec #(.IN_W(SRC_IDX_W), .OUT_W(NUM_SRC)) u_bus_dec (
    .idx    (w_src_idx),
    .en     (w_src_en),
    .onehot (bus_sel)
  );

  onehot_dec #(.IN_W(REG_IDX_W), .OUT_W(NUM_REGS)) u_reg_dec (
    .idx    (r_ra),
    .en     (w_reg_en),
    .onehot (reg_in)
  );

  onehot_dec #(.IN_W(OP_W), .OUT_W(ALU_OPS)) u_alu_dec (
    .idx    (r_op),
    .en     (w_alu_en),
    .onehot (alu_ctl)
  );

  assign busy = (r_state != IDLE);
  assign done = w_done;
  assign err  = w_err;
  assign y_in = w_y;
  assign z_in = w_z;
`ifdef ALU_SEQ_MULDIV_EN
  assign hi_in = w_hi;
  assign lo_in = w_lo;
`else
  assign hi_in = 1'b0;
  assign lo_in = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_step_sequencer
// Brief   : Scoreboard bench for alu_step_sequencer. Each request pushes the
//           expected per-step output vectors; a negedge monitor pops one per
//           busy cycle and checks idle cycles for all-zero outputs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_step_sequencer;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        err;
    logic        y;
    logic        z;
    logic        hi;
    logic        lo;
    logic [23:0] bus;
    logic [15:0] rg;
    logic [9:0]  alu;
  } vec_t;

  logic        clk = 1'b0;
  logic        Clear;
  logic        start;
  logic [3:0]  op;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic [3:0]  rc;
  logic        b_is_mdr;
  logic        busy;
  logic        done;
  logic        err;
  logic [23:0] bus_sel;
  logic [15:0] reg_in;
  logic        y_in;
  logic        z_in;
  logic        hi_in;
  logic        lo_in;
  logic [9:0]  alu_ctl;

  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  vec_t sb[$];
  vec_t act;
  vec_t exp_v;

  always #5 clk = ~clk;

  alu_step_sequencer dut (
    .Clock    (clk),
    .Clear    (Clear),
    .start    (start),
    .op       (op),
    .ra       (ra),
    .rb       (rb),
    .rc       (rc),
    .b_is_mdr (b_is_mdr),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .bus_sel  (bus_sel),
    .reg_in   (reg_in),
    .y_in     (y_in),
    .z_in     (z_in),
    .hi_in    (hi_in),
    .lo_in    (lo_in),
    .alu_ctl  (alu_ctl)
  );

  // Expected busy-cycle vector; index -1 means that one-hot field is zero.
  function automatic vec_t mk(input bit d, input bit e, input bit y, input bit z,
                              input bit h, input bit l,
                              input int bus, input int rg, input int alu);
    vec_t v;
    v      = '0;
    v.busy = 1'b1;
    v.done = d;
    v.err  = e;
    v.y    = y;
    v.z    = z;
    v.hi   = h;
    v.lo   = l;
    if (bus >= 0) v.bus = 24'd1 << bus;
    if (rg  >= 0) v.rg  = 16'd1 << rg;
    if (alu >= 0) v.alu = 10'd1 << alu;
    return v;
  endfunction

  // Monitor: every busy cycle consumes one expectation; idle cycles must be quiet.
  always @(negedge clk) begin
    if (mon_en) begin
      act = {busy, done, err, y_in, z_in, hi_in, lo_in, bus_sel, reg_in, alu_ctl};
      tests++;
      if (busy) begin
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_busy: got %h required no busy cycle", act);
        end else begin
          exp_v = sb.pop_front();
          if (act !== exp_v) begin
            fails++;
            $display("FAIL step: got %h required %h at %0t", act, exp_v, $time);
          end
        end
      end else begin
        if (act !== '0 || sb.size() != 0) begin
          fails++;
          $display("FAIL idle: got %h required 0 (pending %0d) at %0t", act, sb.size(), $time);
        end
      end
    end
  end

  // Drive a request in the current IDLE cycle; returns just after the accepting edge.
  task automatic issue(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic m);
    op = o; ra = a; rb = b; rc = c; b_is_mdr = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Clear = 1'b1; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0; b_is_mdr = 1'b0;
    cycles(2);
    tests++;
    if ({busy, done, err, y_in, z_in, hi_in, lo_in, bus_sel, reg_in, alu_ctl} !== '0) begin
      fails++;
      $display("FAIL reset_state: got busy=%b bus=%h reg=%h required all 0", busy, bus_sel, reg_in);
    end
    Clear = 1'b0;
    mon_en = 1'b1;
    cycles(1);

    // ADD r3 <= r1 + r2
    issue(4'd0, 4'd3, 4'd1, 4'd2, 1'b0);
    sb.push_back(mk(0,0,1,0,0,0, 1, -1, -1));
    sb.push_back(mk(0,0,0,1,0,0, 2, -1, 0));
    sb.push_back(mk(1,0,0,0,0,0, 19, 3, -1));
    cycles(3);

    // NOT r5 <= ~r4 (back-to-back, no Y step)
    issue(4'd4, 4'd5, 4'd4, 4'd9, 1'b0);
    sb.push_back(mk(0,0,0,1,0,0, 4, -1, 4));
    sb.push_back(mk(1,0,0,0,0,0, 19, 5, -1));
    cycles(2);

    // AND r2 <= r7 & MDR
    issue(4'd2, 4'd2, 4'd7, 4'd3, 1'b1);
    sb.push_back(mk(0,0,1,0,0,0, 7, -1, -1));
    sb.push_back(mk(0,0,0,1,0,0, 21, -1, 2));
    sb.push_back(mk(1,0,0,0,0,0, 19, 2, -1));
    cycles(3);

    // MUL r1 <= r2 * r3
    issue(4'd8, 4'd1, 4'd2, 4'd3, 1'b0);
`ifdef ALU_SEQ_MULDIV_EN
    sb.push_back(mk(0,0,1,0,0,0, 2, -1, -1));
    sb.push_back(mk(0,0,0,1,0,0, 3, -1, 8));
    sb.push_back(mk(0,0,0,0,0,1, 19, -1, -1));
    sb.push_back(mk(1,0,0,0,1,0, 18, -1, -1));
    cycles(4);
`else
    sb.push_back(mk(0,1,0,0,0,0, -1, -1, -1));
    cycles(1);
`endif

    // Illegal opcode 12
    issue(4'd12, 4'd1, 4'd1, 4'd1, 1'b0);
    sb.push_back(mk(0,1,0,0,0,0, -1, -1, -1));
    cycles(1);

    // SUB r0 <= r15 - r14 (ra=0 written normally)
    issue(4'd1, 4'd0, 4'd15, 4'd14, 1'b0);
    sb.push_back(mk(0,0,1,0,0,0, 15, -1, -1));
    sb.push_back(mk(0,0,0,1,0,0, 14, -1, 1));
    sb.push_back(mk(1,0,0,0,0,0, 19, 0, -1));
    cycles(3);

    // NEG r0 <= -r15 with b_is_mdr set: unary still reads rb
    issue(4'd5, 4'd0, 4'd15, 4'd2, 1'b1);
    sb.push_back(mk(0,0,0,1,0,0, 15, -1, 5));
    sb.push_back(mk(1,0,0,0,0,0, 19, 0, -1));
    cycles(2);

    // SHL r7 <= r3 << MDR
    issue(4'd6, 4'd7, 4'd3, 4'd0, 1'b1);
    sb.push_back(mk(0,0,1,0,0,0, 3, -1, -1));
    sb.push_back(mk(0,0,0,1,0,0, 21, -1, 6));
    sb.push_back(mk(1,0,0,0,0,0, 19, 7, -1));
    cycles(3);

    // DIV r15 <= r14 / MDR
    issue(4'd9, 4'd15, 4'd14, 4'd13, 1'b1);
`ifdef ALU_SEQ_MULDIV_EN
    sb.push_back(mk(0,0,1,0,0,0, 14, -1, -1));
    sb.push_back(mk(0,0,0,1,0,0, 21, -1, 9));
    sb.push_back(mk(0,0,0,0,0,1, 19, -1, -1));
    sb.push_back(mk(1,0,0,0,1,0, 18, -1, -1));
    cycles(4);
`else
    sb.push_back(mk(0,1,0,0,0,0, -1, -1, -1));
    cycles(1);
`endif

    // Clear during S_ALU: no write step, outputs zero next cycle
    issue(4'd0, 4'd6, 4'd8, 4'd10, 1'b0);
    sb.push_back(mk(0,0,1,0,0,0, 8, -1, -1));
    sb.push_back(mk(0,0,0,1,0,0, 10, -1, 0));
    cycles(1);
    Clear = 1'b1;
    cycles(1);
    Clear = 1'b0;
    cycles(1);

    // start held while busy with changing fields: latched ADD runs unchanged
    op = 4'd0; ra = 4'd4; rb = 4'd5; rc = 4'd6; b_is_mdr = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    sb.push_back(mk(0,0,1,0,0,0, 5, -1, -1));
    sb.push_back(mk(0,0,0,1,0,0, 6, -1, 0));
    sb.push_back(mk(1,0,0,0,0,0, 19, 4, -1));
    op = 4'd1; ra = 4'd9; rb = 4'd10; rc = 4'd11; b_is_mdr = 1'b1;
    cycles(2);
    start = 1'b0;
    cycles(1);

    cycles(3);
    mon_en = 1'b0;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
